// File: rtl/ann_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ann_pkg
// Description : Shared types, state encoding, weight indices and the
//               signed 8-bit saturation helper for the XOR-net trainer.
// Revision    : 1.0 - initial release
// ============================================================================
package ann_pkg;

    typedef logic signed [7:0] weight_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ERR  = 3'd1,
        DH_A = 3'd2,
        DH_B = 3'd3,
        UPD  = 3'd4,
        DONE = 3'd5
    } state_t;

    localparam int W_1A1 = 0;
    localparam int W_1A2 = 1;
    localparam int W_1A3 = 2;
    localparam int W_1B1 = 3;
    localparam int W_1B2 = 4;
    localparam int W_1B3 = 5;
    localparam int W_1C1 = 6;
    localparam int W_1C2 = 7;
    localparam int W_1C3 = 8;
    localparam int NW    = 9;

    // Clamp a sign-extended value into the signed 8-bit range.
    function automatic weight_t sat8(input logic signed [15:0] v);
        if (v > 16'sd127)
            return 8'sh7F;
        else if (v < -16'sd128)
            return 8'sh80;
        else
            return weight_t'(v[7:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ann_sat_mac.sv
`default_nettype none
// ============================================================================
// Module      : ann_sat_mac
// Description : Combinational saturating MAC: 8x8 signed product, arithmetic
//               shift (FRAC, or FRAC+LR_SHIFT when i_lr), sat8, then a
//               saturating add to the accumulator input.
// Revision    : 1.0 - initial release
// ============================================================================
module ann_sat_mac
    import ann_pkg::*;
#(
    parameter int FRAC     = 4,
    parameter int LR_SHIFT = 2
) (
    input  logic signed [7:0] i_a,
    input  logic signed [7:0] i_b,
    input  logic signed [7:0] i_acc,
    input  logic              i_lr,
    output logic signed [7:0] o_sum
);

    logic signed [15:0] w_prod;
    logic signed [15:0] w_shift;
    weight_t            w_term;
    logic signed [8:0]  w_sum9;

    assign w_prod  = i_a * i_b;
    // Learning-rate scaling folds into the same shifter as the fixed-point renormalisation
    assign w_shift = i_lr ? (w_prod >>> (FRAC + LR_SHIFT)) : (w_prod >>> FRAC);
    assign w_term  = sat8(w_shift);
    assign w_sum9  = {i_acc[7], i_acc} + {w_term[7], w_term};
    assign o_sum   = sat8({{7{w_sum9[8]}}, w_sum9});

endmodule
`default_nettype wire

// File: rtl/ann_backprop_trainer.sv
`default_nettype none
// ============================================================================
// Module      : ann_backprop_trainer
// Description : Backward-pass engine for the 2-2-1 XOR network. Computes the
//               output error, both hidden deltas and updates the nine weights
//               in place through one shared saturating MAC.
// Revision    : 1.0 - initial release
// ============================================================================
module ann_backprop_trainer
    import ann_pkg::*;
#(
    parameter int      FRAC     = 4,
    parameter int      LR_SHIFT = 2,
    parameter weight_t WINIT    = 8'sh10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        train,
    input  logic        start,
    input  logic [7:0]  x1,
    input  logic [7:0]  x2,
    input  logic [7:0]  h_a,
    input  logic [7:0]  h_b,
    input  logic [7:0]  y,
    input  logic [7:0]  target,
    input  logic        wload,
    input  logic [3:0]  wsel,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_out,
    output logic [71:0] weights
);

    localparam weight_t c_BIAS = weight_t'(1 << FRAC);

    state_t            r_state;
    state_t            w_next;
    logic              r_busy;
    logic              r_done;
    logic [3:0]        r_k;
    weight_t           r_x1, r_x2, r_ha, r_hb, r_y, r_tgt;
    weight_t           r_err, r_da, r_db;
    weight_t           r_w [NW];

    weight_t           w_mac_a, w_mac_b, w_mac_acc, w_mac_out;
    logic              w_mac_lr;
    logic signed [8:0] w_diff;

    assign w_diff = {r_tgt[7], r_tgt} - {r_y[7], r_y};

    ann_sat_mac #(
        .FRAC     (FRAC),
        .LR_SHIFT (LR_SHIFT)
    ) u_mac (
        .i_a   (w_mac_a),
        .i_b   (w_mac_b),
        .i_acc (w_mac_acc),
        .i_lr  (w_mac_lr),
        .o_sum (w_mac_out)
    );

    // State register with registered busy/done derived from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
        end
    end

    // Next-state logic; a host write in the same cycle suppresses a start
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start && train && !wload) w_next = ERR;
            ERR:     w_next = DH_A;
            DH_A:    w_next = DH_B;
            DH_B:    w_next = UPD;
            UPD:     if (r_k == 4'(NW - 1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // MAC operand steering by state and update index
    always_comb begin
        w_mac_a   = '0;
        w_mac_b   = '0;
        w_mac_acc = '0;
        w_mac_lr  = 1'b0;
        case (r_state)
            DH_A: begin
                w_mac_a = r_err;
                w_mac_b = r_w[W_1C1];
            end
            DH_B: begin
                w_mac_a = r_err;
                w_mac_b = r_w[W_1C2];
            end
            UPD: begin
                w_mac_lr  = 1'b1;
                w_mac_acc = r_w[r_k];
                case (r_k)
                    4'd0:    begin w_mac_a = r_da;  w_mac_b = r_x1;   end
                    4'd1:    begin w_mac_a = r_da;  w_mac_b = r_x2;   end
                    4'd2:    begin w_mac_a = r_da;  w_mac_b = c_BIAS; end
                    4'd3:    begin w_mac_a = r_db;  w_mac_b = r_x1;   end
                    4'd4:    begin w_mac_a = r_db;  w_mac_b = r_x2;   end
                    4'd5:    begin w_mac_a = r_db;  w_mac_b = c_BIAS; end
                    4'd6:    begin w_mac_a = r_err; w_mac_b = r_ha;   end
                    4'd7:    begin w_mac_a = r_err; w_mac_b = r_hb;   end
                    default: begin w_mac_a = r_err; w_mac_b = c_BIAS; end
                endcase
            end
            default: ;
        endcase
    end

    // Datapath: input latch, error/delta capture, in-place weight updates, host writes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_k   <= '0;
            r_x1  <= '0;
            r_x2  <= '0;
            r_ha  <= '0;
            r_hb  <= '0;
            r_y   <= '0;
            r_tgt <= '0;
            r_err <= '0;
            r_da  <= '0;
            r_db  <= '0;
            for (int i = 0; i < NW; i++) r_w[i] <= WINIT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wload) begin
                        if (wsel < 4'(NW)) r_w[wsel] <= wdata;
                    end else if (start && train) begin
                        r_x1  <= x1;
                        r_x2  <= x2;
                        r_ha  <= h_a;
                        r_hb  <= h_b;
                        r_y   <= y;
                        r_tgt <= target;
                    end
                end
                ERR:  r_err <= sat8({{7{w_diff[8]}}, w_diff});
                DH_A: r_da  <= w_mac_out;
                DH_B: r_db  <= w_mac_out;
                UPD: begin
                    r_w[r_k] <= w_mac_out;
                    r_k      <= (r_k == 4'(NW - 1)) ? 4'd0 : r_k + 4'd1;
                end
                default: ;
            endcase
        end
    end

    for (genvar gi = 0; gi < NW; gi++) begin : g_flat
        assign weights[8*gi +: 8] = r_w[gi];
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign err_out = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ann_backprop_trainer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ann_backprop_trainer
// Description : Directed table-driven bench for ann_backprop_trainer plus
//               hand-written sequences for busy-time requests, train gating,
//               wload priority and reset mid-pass.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ann_backprop_trainer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        train = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  x1 = '0, x2 = '0, h_a = '0, h_b = '0, y = '0, target = '0;
    logic        wload = 1'b0;
    logic [3:0]  wsel = '0;
    logic [7:0]  wdata = '0;
    logic        busy, done;
    logic [7:0]  err_out;
    logic [71:0] weights;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [71:0] c_WDEF = {9{8'h10}};

    typedef struct {
        logic [7:0]  x1, x2, ha, hb, y, tgt;
        logic [71:0] wi;
        logic [7:0]  err;
        logic [71:0] we;
    } vec_t;

    vec_t vecs [5];

    ann_backprop_trainer dut (
        .clk     (clk),
        .rst     (rst),
        .train   (train),
        .start   (start),
        .x1      (x1),
        .x2      (x2),
        .h_a     (h_a),
        .h_b     (h_b),
        .y       (y),
        .target  (target),
        .wload   (wload),
        .wsel    (wsel),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .err_out (err_out),
        .weights (weights)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic load_w(input int idx, input logic [7:0] val);
        @(negedge clk);
        wload = 1'b1;
        wsel  = 4'(idx);
        wdata = val;
        @(negedge clk);
        wload = 1'b0;
    endtask

    task automatic set_inputs(input vec_t v);
        x1 = v.x1; x2 = v.x2; h_a = v.ha; h_b = v.hb; y = v.y; target = v.tgt;
    endtask

    // One complete pass from a table entry, sampling #1 into each cycle
    task automatic run_vec(input vec_t v, input int id);
        int ndone;
        int first;
        string t;
        t = $sformatf("v%0d", id);
        ndone = 0;
        first = -1;
        do_reset();
        for (int i = 0; i < 9; i++) load_w(i, v.wi[8*i +: 8]);
        @(negedge clk);
        set_inputs(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            if (c == 1) begin
                x1 = ~v.x1; x2 = ~v.x2; h_a = ~v.ha; h_b = ~v.hb; y = ~v.y; target = ~v.tgt;
                check({t, "_busy_c1"}, 72'(busy), 72'd1);
            end
            if (c == 4) check({t, "_weights_c4"}, weights, v.wi);
            if (c == 14) check({t, "_busy_c14"}, 72'(busy), 72'd0);
            if (done) begin
                ndone++;
                if (first < 0) first = c;
            end
            @(posedge clk);
            #1;
        end
        check({t, "_done_cycle"}, 72'(first), 72'd13);
        check({t, "_done_count"}, 72'(ndone), 72'd1);
        check({t, "_err_out"}, 72'(err_out), 72'(v.err));
        check({t, "_weights"}, weights, v.we);
    endtask

    initial begin
        int ndone;
        int first;

        vecs[0] = '{8'h20, 8'h30, 8'h40, 8'h50, 8'h10, 8'h10, c_WDEF, 8'h00, c_WDEF};
        vecs[1] = '{8'h10, 8'h00, 8'h10, 8'h00, 8'h00, 8'h10, c_WDEF, 8'h10,
                    72'h14_10_14_14_10_14_14_10_14};
        vecs[2] = '{8'h00, 8'h00, 8'h7F, 8'h00, 8'h80, 8'h7F,
                    72'h10_10_7F_10_10_10_10_10_10, 8'h7F,
                    72'h2F_10_7F_2F_10_10_2F_10_10};
        vecs[3] = '{8'h10, 8'h08, 8'h08, 8'h10, 8'h10, 8'h0C, c_WDEF, 8'hFC,
                    {9{8'h0F}}};
        vecs[4] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h10,
                    72'h10_F0_20_10_10_10_10_10_10, 8'h10,
                    72'h14_F4_24_0C_0C_0C_18_18_18};

        // Reset state, sampled while reset is held
        repeat (2) @(negedge clk);
        check("reset_weights", weights, c_WDEF);
        check("reset_busy", 72'(busy), 72'd0);
        check("reset_done", 72'(done), 72'd0);
        check("reset_err_out", 72'(err_out), 72'd0);
        rst = 1'b1;

        // Out-of-range host index is dropped
        load_w(9, 8'h55);
        @(negedge clk);
        check("wsel_out_of_range", weights, c_WDEF);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // start and wload issued in cycle 5 of a pass are ignored
        do_reset();
        ndone = 0;
        first = -1;
        @(negedge clk);
        set_inputs(vecs[1]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                start = 1'b1; wload = 1'b1; wsel = 4'd0; wdata = 8'h00;
            end
            if (c == 6) begin
                start = 1'b0; wload = 1'b0;
            end
            if (c == 14) check("busy_req_busy_c14", 72'(busy), 72'd0);
            if (c == 20) check("busy_req_no_restart", 72'(busy), 72'd0);
            if (done) begin
                ndone++;
                if (first < 0) first = c;
            end
            @(posedge clk);
            #1;
        end
        check("busy_req_done_count", 72'(ndone), 72'd1);
        check("busy_req_done_cycle", 72'(first), 72'd13);
        check("busy_req_weights", weights, vecs[1].we);

        // start without train does not begin a pass
        @(negedge clk);
        train = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        train = 1'b1;
        @(negedge clk);
        check("train_low_busy", 72'(busy), 72'd0);

        // wload wins over a simultaneous start
        do_reset();
        @(negedge clk);
        set_inputs(vecs[1]);
        start = 1'b1; wload = 1'b1; wsel = 4'd0; wdata = 8'h33;
        @(posedge clk);
        #1;
        start = 1'b0; wload = 1'b0;
        check("wload_prio_weight", weights, {{8{8'h10}}, 8'h33});
        check("wload_prio_busy", 72'(busy), 72'd0);
        @(posedge clk);
        #1;
        check("wload_prio_busy_next", 72'(busy), 72'd0);

        // Reset asserted in cycle 8 (UPD, k=4) aborts and restores weights
        do_reset();
        ndone = 0;
        @(negedge clk);
        set_inputs(vecs[1]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            @(posedge clk);
            #1;
        end
        check("midpass_partial_w0", 72'(weights[7:0]), 72'h14);
        #1;
        rst = 1'b0;
        #1;
        check("midpass_busy", 72'(busy), 72'd0);
        check("midpass_weights", weights, c_WDEF);
        check("midpass_done", 72'(done), 72'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("midpass_no_done", 72'(ndone), 72'd0);
        check("midpass_weights_after", weights, c_WDEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
